// File: rtl/prf_pkg.sv
// Shared definitions for the multi-port physical register file.
package prf_pkg;

  localparam int unsigned PRF_DW_DEF    = 32;
  localparam int unsigned PRF_DEPTH_DEF = 64;
  localparam int unsigned PRF_ZERO_TAG  = 0;

  // Least significant bit of lane/port `lane` in a flattened bus of `width`-bit slices.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/prf_wr_merge.sv
// Priority reduce of all CDB write lanes against one tag: reports whether any
// lane writes it, the data of the highest-numbered such lane, and whether more
// than one lane hit. Tag 0 never hits, so writes to it vanish here.
module prf_wr_merge
  import prf_pkg::*;
#(
  parameter int unsigned DW  = PRF_DW_DEF,
  parameter int unsigned AW  = 6,
  parameter int unsigned NWR = 1
) (
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic [NWR*DW-1:0] wr_data_i,
  input  logic [AW-1:0]     tag_i,
  output logic              hit_o,
  output logic [DW-1:0]     data_o,
  output logic              multi_o
);

  // Walk lanes low to high so the last matching lane's data survives.
  always_comb begin
    // NOTE: blocking assignments here are deliberate: each lane iteration must
    // see the hit/data left by the previous one within the same evaluation.
    hit_o   = 1'b0;
    data_o  = '0;
    multi_o = 1'b0;
    for (int unsigned l = 0; l < NWR; l++) begin
      if (wr_en_i[l] && (tag_i != AW'(PRF_ZERO_TAG)) &&
          (wr_addr_i[lane_lsb(l, AW) +: AW] == tag_i)) begin
        multi_o = multi_o | hit_o;
        hit_o   = 1'b1;
        data_o  = wr_data_i[lane_lsb(l, DW) +: DW];
      end
    end
  end

endmodule

// File: rtl/prf_mp.sv
// Multi-port physical register file with per-register ready scoreboard.
// Reads are registered (latency 1) and see same-edge writes and allocs.
module prf_mp
  import prf_pkg::*;
#(
  parameter int unsigned DW    = PRF_DW_DEF,
  parameter int unsigned DEPTH = PRF_DEPTH_DEF,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 1,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_rdy,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR*DW-1:0] wr_data,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  output logic              wr_conflict
);

  logic [DW-1:0]     mem_q [DEPTH];
  logic [DW-1:0]     mem_d [DEPTH];
  logic [DEPTH-1:0]  rdy_q, rdy_d;

  logic [DEPTH-1:0]  ent_hit, ent_multi;
  logic [DW-1:0]     ent_data [DEPTH];

  logic [AW-1:0]     rd_tag   [NRD];
  logic [NRD-1:0]    byp_hit, byp_multi;
  logic [DW-1:0]     byp_data [NRD];

  logic [NRD*DW-1:0] rd_data_q, rd_data_d;
  logic [NRD-1:0]    rd_rdy_q, rd_rdy_d;
  logic              conflict_q, conflict_d;

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    prf_wr_merge #(.DW(DW), .AW(AW), .NWR(NWR)) u_merge (
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .tag_i     (AW'(e)),
      .hit_o     (ent_hit[e]),
      .data_o    (ent_data[e]),
      .multi_o   (ent_multi[e])
    );
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign rd_tag[i] = rd_addr[i*AW +: AW];
    prf_wr_merge #(.DW(DW), .AW(AW), .NWR(NWR)) u_byp (
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .tag_i     (rd_tag[i]),
      .hit_o     (byp_hit[i]),
      .data_o    (byp_data[i]),
      .multi_o   (byp_multi[i])
    );
  end

  // Storage/scoreboard update; an alloc to a tag overrides a same-edge completion.
  always_comb begin
    // NOTE: every element gets a value on every path, so no latch is inferred.
    for (int unsigned e = 0; e < DEPTH; e++) begin
      mem_d[e] = ent_hit[e] ? ent_data[e] : mem_q[e];
      rdy_d[e] = rdy_q[e] | ent_hit[e];
      if (alloc_en && (alloc_addr == AW'(e)) && (e != PRF_ZERO_TAG)) rdy_d[e] = 1'b0;
    end
  end

  // Read ports with write/alloc bypass; byp_multi is a subset of ent_multi and
  // is folded in only so every merge output is consumed.
  always_comb begin
    rd_data_d = '0;
    rd_rdy_d  = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      rd_data_d[i*DW +: DW] = byp_hit[i] ? byp_data[i] : mem_q[rd_tag[i]];
      rd_rdy_d[i] = (byp_hit[i] | rdy_q[rd_tag[i]]) &
                    ~(alloc_en && (alloc_addr == rd_tag[i]) &&
                      (rd_tag[i] != AW'(PRF_ZERO_TAG)));
    end
    conflict_d = (|ent_multi) | (|byp_multi);
  end

  // State and output registers; reset overrides every write, alloc and read.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage array is reset explicitly because every entry must read as zero after reset.
      for (int unsigned e = 0; e < DEPTH; e++) mem_q[e] <= '0;
      rdy_q      <= '1;
      rd_data_q  <= '0;
      rd_rdy_q   <= '1;
      conflict_q <= 1'b0;
    end else begin
      for (int unsigned e = 0; e < DEPTH; e++) mem_q[e] <= mem_d[e];
      rdy_q      <= rdy_d;
      rd_data_q  <= rd_data_d;
      rd_rdy_q   <= rd_rdy_d;
      conflict_q <= conflict_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_rdy      = rd_rdy_q;
  assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_prf_mp.sv
// Self-checking bench for prf_mp (NRD=2, NWR=2) against a per-cycle array model.
module tb_prf_mp;

  localparam int DW = 32, DEPTH = 64, NRD = 2, NWR = 2, AW = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_rdy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              alloc_en;
  logic [AW-1:0]     alloc_addr;
  logic              wr_conflict;

  prf_mp #(.DW(DW), .DEPTH(DEPTH), .NRD(NRD), .NWR(NWR)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_rdy(rd_rdy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: register contents and ready bits.
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_rdy [DEPTH];
  logic [DW-1:0] e_data [NRD];
  logic          e_rdy  [NRD];
  logic          e_conf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] tag_of(input logic [NWR*AW-1:0] bus, input int k);
    return bus[k*AW +: AW];
  endfunction

  task automatic set_idle();
    rst = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; rd_addr = '0;
  endtask

  task automatic set_wr(input int lane, input int tag, input logic [DW-1:0] d);
    wr_en[lane] = 1'b1;
    wr_addr[lane*AW +: AW] = AW'(tag);
    wr_data[lane*DW +: DW] = d;
  endtask

  task automatic set_rd(input int port, input int tag);
    rd_addr[port*AW +: AW] = AW'(tag);
  endtask

  // One clock edge: advance the model by the spec's rules, then compare outputs.
  task automatic tick(input string name);
    logic [AW-1:0] a;
    int hits [DEPTH];
    @(posedge clk);
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin m_mem[r] = '0; m_rdy[r] = 1'b1; end
      for (int p = 0; p < NRD; p++) begin e_data[p] = '0; e_rdy[p] = 1'b1; end
      e_conf = 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++) hits[r] = 0;
      for (int l = 0; l < NWR; l++) begin
        a = tag_of(wr_addr, l);
        if (wr_en[l] && a != 0) begin
          m_mem[a] = wr_data[l*DW +: DW];
          m_rdy[a] = 1'b1;
          hits[a]++;
        end
      end
      if (alloc_en && alloc_addr != 0) m_rdy[alloc_addr] = 1'b0;
      e_conf = 1'b0;
      for (int r = 0; r < DEPTH; r++) if (hits[r] > 1) e_conf = 1'b1;
      for (int p = 0; p < NRD; p++) begin
        a = rd_addr[p*AW +: AW];
        e_data[p] = m_mem[a];
        e_rdy[p]  = m_rdy[a];
      end
    end
    #1;
    for (int p = 0; p < NRD; p++) begin
      check($sformatf("%s rd_data[%0d]", name, p), 64'(rd_data[p*DW +: DW]), 64'(e_data[p]));
      check($sformatf("%s rd_rdy[%0d]", name, p), 64'(rd_rdy[p]), 64'(e_rdy[p]));
    end
    check($sformatf("%s wr_conflict", name), 64'(wr_conflict), 64'(e_conf));
  endtask

  initial begin
    for (int r = 0; r < DEPTH; r++) begin m_mem[r] = '0; m_rdy[r] = 1'b1; end
    set_idle();

    // Reset held two cycles while a write is attempted.
    rst = 1'b1; set_wr(0, 5, 32'hDEAD); set_rd(0, 5);
    tick("reset0"); tick("reset1");
    set_idle(); set_rd(0, 5);
    tick("post_reset");
    check("post_reset literal", 64'(rd_data[0 +: DW]), 64'h0);

    // Basic write then read.
    set_idle(); set_wr(0, 7, 32'h1234_5678);
    tick("wr7");
    set_idle(); set_rd(0, 7);
    tick("rd7");
    check("rd7 literal", 64'(rd_data[0 +: DW]), 64'h1234_5678);

    // Same-edge write bypass on port 1.
    set_idle(); set_wr(1, 9, 32'hA5A5_A5A5); set_rd(1, 9);
    tick("bypass9");
    check("bypass9 literal", 64'(rd_data[DW +: DW]), 64'hA5A5_A5A5);

    // Scoreboard: alloc, pending reads, completion, alloc-wins.
    set_idle(); alloc_en = 1'b1; alloc_addr = 6'd12; set_rd(0, 12);
    tick("alloc12");
    check("alloc12 literal", 64'(rd_rdy[0]), 64'h0);
    set_idle(); set_rd(0, 12);
    tick("pend12a"); tick("pend12b");
    set_wr(0, 12, 32'h42);
    tick("done12");
    check("done12 literal", 64'(rd_rdy[0]), 64'h1);
    set_idle(); alloc_en = 1'b1; alloc_addr = 6'd12; set_wr(1, 12, 32'h77); set_rd(0, 12);
    tick("alloc_wr12");
    check("alloc_wr12 literal", 64'(rd_rdy[0]), 64'h0);

    // Zero register: both lanes and alloc target tag 0.
    set_idle(); set_wr(0, 0, 32'hFFFF_FFFF); set_wr(1, 0, 32'hFFFF_FFFF);
    alloc_en = 1'b1; alloc_addr = '0; set_rd(0, 0);
    tick("zero");
    set_idle(); set_rd(0, 0);
    tick("zero_after");

    // Same-tag conflict: lane 1 wins, flag for exactly one cycle.
    set_idle(); set_wr(0, 3, 32'h11); set_wr(1, 3, 32'h22); set_rd(1, 3);
    tick("conflict");
    check("conflict literal", 64'(wr_conflict), 64'h1);
    set_idle(); set_rd(1, 3);
    tick("conflict_clear");
    check("conflict_clear literal", 64'(wr_conflict), 64'h0);

    // Randomised traffic over a narrow tag range to force collisions.
    for (int n = 0; n < 600; n++) begin
      set_idle();
      rst = ($urandom_range(0, 59) == 0);
      for (int l = 0; l < NWR; l++)
        if ($urandom_range(0, 1) == 1)
          set_wr(l, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7),
                 $urandom);
      if ($urandom_range(0, 3) == 0) begin
        alloc_en   = 1'b1;
        alloc_addr = AW'($urandom_range(0, 7));
      end
      for (int p = 0; p < NRD; p++)
        set_rd(p, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7));
      tick("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prf_mp.md
Name: prf_mp

Overview:
- Parametrised multi-port physical register file for the out-of-order pipeline; successor to the 2-read/1-write 64x32 PRF.
- Single-clock, flop-based, no clock multiplier.
- N read ports (issue/regread stage), M write ports (CDB lanes), and a per-register ready scoreboard.
- Ready bits are cleared at rename allocation and set at completion.
- Physical register 0 is hardwired zero/always-ready.

Parameters:
- DW, 32, data width in bits.
- DEPTH, 64, number of physical registers; power of two, >=4.
- NRD, 2, number of read ports.
- NWR, 1, number of write (CDB) ports.
- AW, $clog2(DEPTH), localparam tag width; not overridable.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rd_addr  in  NRD*AW  read tags; port i at bits [i*AW +: AW].
- rd_data  out  NRD*DW  registered read data; port i at [i*DW +: DW].
- rd_rdy  out  NRD  registered ready bit of the tag read on port i.
- wr_en  in  NWR  per-lane write enable (CDB valid & RegDest).
- wr_addr  in  NWR*AW  write tags per lane.
- wr_data  in  NWR*DW  write data per lane.
- alloc_en  in  1  rename allocates a new destination tag.
- alloc_addr  in  AW  tag being allocated; its ready bit is cleared.
- wr_conflict  out  1  registered flag: two enabled lanes wrote the same nonzero tag last cycle.

Behaviour:
- Reset (rst=1 at posedge clk): all entries <= 0; all ready bits <= 1; rd_data <= 0; rd_rdy <= all 1; wr_conflict <= 0. All writes, allocs and reads are ignored that cycle.
- Write: at posedge, for each lane with wr_en=1 and wr_addr!=0, the entry <= wr_data and ready <= 1.
- Writes to tag 0 are dropped; entry 0 stays 0 and ready stays 1.
- Same-tag multi-write: the highest-numbered lane wins for data. wr_conflict = 1 on the following cycle, held for one cycle only.
- Alloc: at posedge, if alloc_en=1 and alloc_addr!=0, ready[alloc_addr] <= 0. Data is unchanged.
- Alloc and write to the same tag in the same cycle: alloc wins, so ready ends 0 and the data is still written. A completion to a freshly reallocated tag is stale.
- Read: latency 1. rd_addr is sampled at posedge N; rd_data/rd_rdy are valid after posedge N, stable for the whole of cycle N+1.
- Write bypass: if a lane writes tag T at posedge N and port i reads T at the same edge, rd_data[i] = the new data (highest lane wins) and rd_rdy[i] = 1. The alloc-wins rule above still applies to rd_rdy.
- Alloc bypass: a same-edge alloc of T makes rd_rdy[i] = 0 for readers of T.
- Read of tag 0: rd_data = 0, rd_rdy = 1, regardless of writes or allocs.
- Out-of-range tags: impossible, since DEPTH is a power of two.
- Reset mid-operation: rst wins over every write, alloc and read in that cycle; the state after that edge equals the post-reset state.

Decomposition:
- Shared package (prf_pkg.vh include):
  - default DW/DEPTH;
  - PRF_ZERO_TAG = 0;
  - lane-slice helper macros for packing and unpacking flattened buses.
- One sub-module, prf_wr_merge: combinational priority reduce over the NWR lanes for a given tag, producing hit, data (highest lane) and multi-hit.
  - Instanced once per entry for the storage update.
  - Instanced once per read port for the bypass path.
  - Its multi-hit outputs are ORed to form wr_conflict.
- Storage, ready vector and output registers live in prf_mp.

Test Plan:
- Reset: hold rst=1 for 2 cycles with wr_en=1, wr_addr=5, wr_data=32'hDEAD -> afterwards a read of tag 5 gives rd_data=0, rd_rdy=1, and wr_conflict=0.
- Basic write/read: write tag 7 = 32'h1234_5678 at edge N; read 7 at edge N+1 -> rd_data=32'h12345678 and rd_rdy=1 after edge N+1.
- Same-edge bypass: write tag 9 = 32'hA5A5_A5A5 and read tag 9 at the same edge -> rd_data=32'hA5A5A5A5 on the next cycle, not the old value.
- Scoreboard: alloc tag 12 at edge N -> reads at N and N+1 give rd_rdy=0. Write tag 12 = 32'h42 at N+3 -> a read at N+3 gives rd_rdy=1, rd_data=32'h42. Alloc and write tag 12 at the same edge -> rd_rdy=0.
- Zero register: NWR=2, both lanes write tag 0 with 32'hFFFF_FFFF and alloc 0 at the same edge -> a read of tag 0 gives 0 with rd_rdy=1, and wr_conflict=0.
- Conflict: NWR=2, lane0 writes tag 3 = 32'h11 and lane1 writes tag 3 = 32'h22 at edge N -> a read of 3 gives 32'h22; wr_conflict=1 only in the cycle after N.
